// File: rtl/irq_priority_scheduler_pkg.sv
// Shared definitions for the interrupt priority scheduler.
//   NUM_LINES : number of request lines
//   ID_W      : width of a line index
//   COUNT_W   : width of the completed-grant counter
//   state_t   : scheduler FSM states
package irq_priority_scheduler_pkg;

   localparam int NUM_LINES = 16;
   localparam int ID_W      = 4;
   localparam int COUNT_W   = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_GAP
   } state_t;

endpackage

// File: rtl/irq_priority_scheduler_priority_encoder.sv
// MSB-first priority encoder over the request lines.
//   in_bits              : input vector
//   most_significant_bit : index of the highest set bit (0 when none set)
//   multiple_ones        : more than one bit of in_bits is set
module priority_encoder
   import irq_priority_scheduler_pkg::*;
(
   input  logic [NUM_LINES-1:0] in_bits,
   output logic [ID_W-1:0]      most_significant_bit,
   output logic                 multiple_ones
);

   logic [NUM_LINES-1:0] low_cleared;

   always_comb begin
      most_significant_bit = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
         if (in_bits[i]) begin
            most_significant_bit = i[ID_W-1:0];
         end
      end
   end

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign low_cleared   = in_bits & (in_bits - {{(NUM_LINES-1){1'b0}}, 1'b1});
   assign multiple_ones = |low_cleared;

endmodule

// File: rtl/irq_priority_scheduler.sv
// Interrupt priority scheduler: latches request strobes into a sticky pending
// register, filters them with a writable mask and presents the highest-index
// eligible line to a single servicer on a valid/ack handshake.
//   clk, rst         : clock, asynchronous active-high reset
//   req              : request strobes, each high bit sets its pending bit
//   mask_we, mask_in : mask register write (1 = line not grantable)
//   ack              : servicer accepts the current grant (ignored outside GRANT)
//   grant_valid      : a grant is being presented
//   grant_id         : index of the granted line, stable while grant_valid=1
//   pending          : current pending register
//   multiple_pending : more than one unmasked pending bit
//   grant_count      : completed grants, wrapping
//
// state   | meaning
// S_IDLE  | no grant outstanding; selects the highest eligible line
// S_GRANT | grant_id presented, waiting for ack
// S_GAP   | one dead cycle after ack so the servicer can drop ack
module irq_priority_scheduler
   import irq_priority_scheduler_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_LINES-1:0] req,
   input  logic                 mask_we,
   input  logic [NUM_LINES-1:0] mask_in,
   input  logic                 ack,
   output logic                 grant_valid,
   output logic [ID_W-1:0]      grant_id,
   output logic [NUM_LINES-1:0] pending,
   output logic                 multiple_pending,
   output logic [COUNT_W-1:0]   grant_count
);

   state_t               state_q, state_d;
   logic [NUM_LINES-1:0] mask_q;
   logic [NUM_LINES-1:0] eligible;
   logic [NUM_LINES-1:0] clr;
   logic [ID_W-1:0]      sel_id;
   logic                 any;
   logic                 ack_grant;
   logic                 load_id;

   assign eligible  = pending & ~mask_q;
   assign any       = |eligible;
   assign ack_grant = (state_q == S_GRANT) && ack;

   priority_encoder u_prio (
      .in_bits              (eligible),
      .most_significant_bit (sel_id),
      .multiple_ones        (multiple_pending)
   );

   always_comb begin
      clr = '0;
      if (ack_grant) begin
         clr[grant_id] = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_valid = 1'b0;
      load_id     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (any) begin
               load_id = 1'b1;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            grant_valid = 1'b1;
            if (ack) begin
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         grant_id    <= '0;
         pending     <= '0;
         mask_q      <= '0;
         grant_count <= '0;
      end else begin
         state_q <= state_d;
         // A new strobe on the bit being cleared keeps it pending.
         pending <= (pending & ~clr) | req;
         if (mask_we) begin
            mask_q <= mask_in;
         end
         if (load_id) begin
            grant_id <= sel_id;
         end
         if (ack_grant) begin
            grant_count <= grant_count + COUNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_irq_priority_scheduler.sv
module tb_irq_priority_scheduler;
   import irq_priority_scheduler_pkg::*;

   logic                 clk;
   logic                 rst;
   logic [NUM_LINES-1:0] req;
   logic                 mask_we;
   logic [NUM_LINES-1:0] mask_in;
   logic                 ack;
   logic                 grant_valid;
   logic [ID_W-1:0]      grant_id;
   logic [NUM_LINES-1:0] pending;
   logic                 multiple_pending;
   logic [COUNT_W-1:0]   grant_count;

   int n_vec;
   int n_err;
   logic [ID_W-1:0]    exp_q[$];
   logic [COUNT_W-1:0] exp_count;

   irq_priority_scheduler dut (
      .clk              (clk),
      .rst              (rst),
      .req              (req),
      .mask_we          (mask_we),
      .mask_in          (mask_in),
      .ack              (ack),
      .grant_valid      (grant_valid),
      .grant_id         (grant_id),
      .pending          (pending),
      .multiple_pending (multiple_pending),
      .grant_count      (grant_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input string name);
      int budget;
      budget = 0;
      while (!grant_valid && budget < 10) begin
         tick();
         budget++;
      end
      check({name, "_grant_timeout"}, {31'd0, grant_valid}, 32'd1);
   endtask

   // One complete request/grant/ack transaction on a single line, from IDLE.
   task automatic do_grant(input int id);
      exp_q.push_back(id[ID_W-1:0]);
      req = NUM_LINES'(1) << id;
      tick();
      req = '0;
      wait_grant("do_grant");
      ack = 1'b1;
      tick();
      ack = 1'b0;
      exp_count++;
      tick();
   endtask

   // Scoreboard monitor: every newly presented grant is matched against the
   // next expected id; a held grant must not change its id.
   logic            prev_valid;
   logic [ID_W-1:0] prev_id;
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (grant_valid && !prev_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_grant: got id %0d with no grant expected", grant_id);
            end else begin
               logic [ID_W-1:0] e;
               e = exp_q.pop_front();
               if (grant_id !== e) begin
                  n_err++;
                  $display("FAIL grant_order: got id %0d expected %0d", grant_id, e);
               end
            end
         end else if (grant_valid && prev_valid) begin
            n_vec++;
            if (grant_id !== prev_id) begin
               n_err++;
               $display("FAIL grant_stable: got id %0d expected %0d", grant_id, prev_id);
            end
         end
         prev_valid = grant_valid;
         prev_id    = grant_id;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec     = 0;
      n_err     = 0;
      exp_count = '0;
      rst       = 1'b1;
      req       = '0;
      mask_we   = 1'b0;
      mask_in   = '0;
      ack       = 1'b0;
      #12;
      check("rst_valid",   {31'd0, grant_valid}, 32'd0);
      check("rst_id",      {28'd0, grant_id}, 32'd0);
      check("rst_pending", {16'd0, pending}, 32'd0);
      check("rst_count",   {24'd0, grant_count}, 32'd0);
      check("rst_multi",   {31'd0, multiple_pending}, 32'd0);
      tick();
      rst = 1'b0;

      // Single request: pending after one edge, grant after two.
      exp_q.push_back(4'd0);
      req = 16'h0001;
      tick();
      req = '0;
      check("t1_pending",  {16'd0, pending}, 32'h0001);
      check("t1_valid_n1", {31'd0, grant_valid}, 32'd0);
      tick();
      check("t1_valid_n2", {31'd0, grant_valid}, 32'd1);
      check("t1_id",       {28'd0, grant_id}, 32'd0);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      exp_count++;
      check("t1_pend_clr", {16'd0, pending}, 32'h0000);
      check("t1_count",    {24'd0, grant_count}, {24'd0, exp_count});
      check("t1_gap",      {31'd0, grant_valid}, 32'd0);
      tick();

      // Four lines, ack held: 15,10,5,0 one grant per 3 cycles.
      exp_q.push_back(4'd15);
      exp_q.push_back(4'd10);
      exp_q.push_back(4'd5);
      exp_q.push_back(4'd0);
      req = 16'h8421;
      ack = 1'b1;
      tick();
      req = '0;
      check("t2_multi_start", {31'd0, multiple_pending}, 32'd1);
      for (int t = 2; t <= 12; t++) begin
         tick();
         if (t == 5 || t == 8) check("t2_spacing", {31'd0, grant_valid}, 32'd1);
         if (t == 6) check("t2_multi_mid", {31'd0, multiple_pending}, 32'd1);
         if (t == 9) check("t2_multi_end", {31'd0, multiple_pending}, 32'd0);
      end
      ack = 1'b0;
      exp_count += 8'd4;
      tick();
      check("t2_count",   {24'd0, grant_count}, {24'd0, exp_count});
      check("t2_pending", {16'd0, pending}, 32'h0000);

      // Masked line waits until the mask is cleared.
      exp_q.push_back(4'd4);
      req     = 16'h0090;
      mask_we = 1'b1;
      mask_in = 16'h0080;
      tick();
      req     = '0;
      mask_we = 1'b0;
      wait_grant("t3_first");
      check("t3_id4", {28'd0, grant_id}, 32'd4);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      exp_count++;
      repeat (5) tick();
      check("t3_held_off",  {31'd0, grant_valid}, 32'd0);
      check("t3_pending",   {16'd0, pending}, 32'h0080);
      exp_q.push_back(4'd7);
      mask_we = 1'b1;
      mask_in = 16'h0000;
      tick();
      mask_we = 1'b0;
      wait_grant("t3_second");
      check("t3_id7", {28'd0, grant_id}, 32'd7);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      exp_count++;
      tick();
      // Ack while idle changes nothing.
      ack = 1'b1;
      repeat (2) tick();
      ack = 1'b0;
      check("t3_idle_ack", {24'd0, grant_count}, {24'd0, exp_count});

      // Re-request on the ack edge: set wins, line granted again after GAP.
      exp_q.push_back(4'd3);
      exp_q.push_back(4'd3);
      req = 16'h0008;
      tick();
      req = '0;
      wait_grant("t4_first");
      ack = 1'b1;
      req = 16'h0008;
      tick();
      ack = 1'b0;
      req = '0;
      exp_count++;
      check("t4_set_wins", {16'd0, pending}, 32'h0008);
      check("t4_gap",      {31'd0, grant_valid}, 32'd0);
      tick();
      tick();
      check("t4_regrant", {31'd0, grant_valid}, 32'd1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      exp_count++;
      tick();

      // No preemption and no revocation by mask during GRANT.
      exp_q.push_back(4'd2);
      exp_q.push_back(4'd9);
      req = 16'h0004;
      tick();
      req = '0;
      wait_grant("t5_first");
      req     = 16'h0200;
      mask_we = 1'b1;
      mask_in = 16'h0004;
      tick();
      req     = '0;
      mask_we = 1'b0;
      repeat (2) tick();
      check("t5_hold_valid", {31'd0, grant_valid}, 32'd1);
      check("t5_hold_id",    {28'd0, grant_id}, 32'd2);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      exp_count++;
      wait_grant("t5_second");
      check("t5_id9", {28'd0, grant_id}, 32'd9);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      exp_count++;
      mask_we = 1'b1;
      mask_in = '0;
      tick();
      mask_we = 1'b0;

      // Run the counter up to 255, then wrap.
      for (int i = 0; exp_count != 8'd255; i++) begin
         do_grant(i % NUM_LINES);
      end
      check("t6_count_255", {24'd0, grant_count}, 32'd255);
      do_grant(6);
      check("t6_count_wrap", {24'd0, grant_count}, 32'd0);

      // Asynchronous reset in the middle of a grant.
      exp_q.push_back(4'd1);
      req = 16'h0003;
      tick();
      req = '0;
      wait_grant("t7");
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("t7_valid",   {31'd0, grant_valid}, 32'd0);
      check("t7_id",      {28'd0, grant_id}, 32'd0);
      check("t7_pending", {16'd0, pending}, 32'd0);
      check("t7_count",   {24'd0, grant_count}, 32'd0);
      check("t7_multi",   {31'd0, multiple_pending}, 32'd0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check("t7_no_grant", {31'd0, grant_valid}, 32'd0);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
